// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: bus widths and the arbiter FSM state encoding.
package mem_arbiter_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last_grant+1, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      cand  = '0;
      // i runs 1..NUM_REQ so last_grant itself is tried last
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((32'(last_grant) + i) % NUM_REQ);
         if (!any && req[cand]) begin
            grant = cand;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory interface among NUM_REQ requesters,
// one transaction outstanding, with a WAIT-state timeout that returns an error response.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                fclk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][MEM_ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ-1:0]                  req_we,
   input  logic [NUM_REQ-1:0][MEM_DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   output logic [MEM_DATA_W-1:0]               rsp_data,
   output logic                                rsp_err,
   output logic                                mem_req_valid,
   input  logic                                mem_req_ready,
   output logic [MEM_ADDR_W-1:0]               mem_addr,
   output logic                                mem_we,
   output logic [MEM_DATA_W-1:0]               mem_wdata,
   input  logic                                mem_rsp_valid,
   input  logic [MEM_DATA_W-1:0]               mem_rsp_data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_e       state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] grant_q;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nxt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (pick_idx),
      .any        (pick_any)
   );

   always_comb begin
      req_ready = '0;
      if (state == ST_IDLE && pick_any) begin
         req_ready[pick_idx] = 1'b1;
      end
   end

   always_comb begin
      timer_nxt = timer + TMR_W'(1);
   end

   always_ff @(posedge fclk) begin
      if (rst) begin
         state         <= ST_IDLE;
         last_grant    <= IDX_W'(NUM_REQ - 1);
         grant_q       <= '0;
         timer         <= '0;
         rsp_data      <= '0;
         rsp_valid     <= '0;
         rsp_err       <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_we        <= 1'b0;
         mem_wdata     <= '0;
      end else begin
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_q       <= pick_idx;
                  mem_addr      <= req_addr[pick_idx];
                  mem_we        <= req_we[pick_idx];
                  mem_wdata     <= req_wdata[pick_idx];
                  mem_req_valid <= 1'b1;
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  timer         <= '0;
                  state         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // response takes priority over a timeout expiring in the same cycle
               if (mem_rsp_valid) begin
                  if (!mem_we) begin
                     rsp_data <= mem_rsp_data;
                  end
                  rsp_valid[grant_q] <= 1'b1;
                  rsp_err            <= 1'b0;
                  state              <= ST_RESP;
               end else begin
                  timer <= timer_nxt;
                  if (timer_nxt == TMR_W'(TIMEOUT_CYCLES)) begin
                     rsp_valid[grant_q] <= 1'b1;
                     rsp_err            <= 1'b1;
                     state              <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               last_grant <= grant_q;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected responses, memory responder driven inline.
module tb_mem_arbiter;

   localparam int NREQ = 2;
   localparam int TMO  = 8;

   logic                  fclk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0][31:0] req_addr;
   logic [NREQ-1:0]       req_we;
   logic [NREQ-1:0][127:0] req_wdata;
   logic [NREQ-1:0]       rsp_valid;
   logic [127:0]          rsp_data;
   logic                  rsp_err;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [31:0]           mem_addr;
   logic                  mem_we;
   logic [127:0]          mem_wdata;
   logic                  mem_rsp_valid;
   logic [127:0]          mem_rsp_data;

   mem_arbiter #(
      .NUM_REQ        (NREQ),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .fclk          (fclk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_we        (req_we),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
   );

   always #5 fclk = ~fclk;

   typedef struct {
      logic [1:0]   vld;
      logic [127:0] data;
      logic         err;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   int           grant_log[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           grant_cyc = 0;
   int           rsp_count = 0;
   logic [127:0] model_data;

   always @(posedge fclk) cyc++;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge fclk) begin
      if (!rst && req_ready !== 2'b00) begin
         chk("ready_onehot", ((req_ready & (req_ready - 2'd1)) == 2'b00), 1'b1);
         chk("ready_has_valid", ((req_ready & ~req_valid) == 2'b00), 1'b1);
         grant_log.push_back(req_ready[1] ? 1 : 0);
         grant_cyc = cyc;
      end
   end

   always @(negedge fclk) begin
      exp_t e;
      if (!rst && rsp_valid !== 2'b00) begin
         rsp_count++;
         chk("rsp_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_valid", rsp_valid, e.vld);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_data", rsp_data, e.data);
            if (e.lat >= 0) chk("rsp_latency", cyc - grant_cyc, e.lat);
         end
      end
   end

   task automatic push_exp(input int idx, input logic err, input int lat);
      exp_t e;
      e.vld  = (idx == 0) ? 2'b01 : 2'b10;
      e.data = model_data;
      e.err  = err;
      e.lat  = lat;
      sb.push_back(e);
   endtask

   task automatic request(input int idx, input logic [31:0] a, input logic we,
                          input logic [127:0] wd, input logic [1:0] extra);
      bit seen;
      seen = 1'b0;
      @(posedge fclk); #1;
      req_addr[idx]  = a;
      req_we[idx]    = we;
      req_wdata[idx] = wd;
      req_valid[idx] = 1'b1;
      req_valid      = req_valid | extra;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge fclk);
         if (req_ready[idx] === 1'b1) seen = 1'b1;
      end
      chk("grant_seen", seen, 1'b1);
      @(posedge fclk); #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic mem_cycle(input int rdy_lat, input bit give_rsp, input int rsp_lat,
                            input logic [127:0] rdata, input logic [31:0] ea, input logic ewe,
                            input logic [127:0] ewd, input bit stray);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge fclk);
         if (mem_req_valid === 1'b1) seen = 1'b1;
      end
      chk("mem_req_seen", seen, 1'b1);
      chk("mem_addr", mem_addr, ea);
      chk("mem_we", mem_we, ewe);
      chk("mem_wdata", mem_wdata, ewd);
      for (int i = 0; i < rdy_lat; i++) begin
         if (stray) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {4{32'hBAD0_0000 | i}};
         end
         @(negedge fclk);
         chk("stall_valid", mem_req_valid, 1'b1);
         chk("stall_addr", mem_addr, ea);
         chk("stall_we", mem_we, ewe);
         chk("stall_wdata", mem_wdata, ewd);
         chk("stall_ready", req_ready, 2'b00);
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge fclk); #1;
      mem_req_ready = 1'b0;
      if (give_rsp) begin
         for (int i = 0; i < rsp_lat; i++) begin
            @(posedge fclk); #1;
         end
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = rdata;
         @(posedge fclk); #1;
         mem_rsp_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge fclk); #1;
         if (sb.size() == 0) done = 1'b1;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int base_rsp;
      rst           = 1'b1;
      req_valid     = '0;
      req_addr      = '0;
      req_we        = '0;
      req_wdata     = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      model_data    = '0;

      repeat (3) @(posedge fclk);
      @(negedge fclk);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_wdata", mem_wdata, 128'h0);
      chk("rst_rsp_data", rsp_data, 128'h0);
      @(posedge fclk); #1;
      rst = 1'b0;

      // single read, memory answers three cycles into WAIT
      model_data = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
      push_exp(0, 1'b0, 6);
      request(0, 32'h100, 1'b0, '0, 2'b00);
      mem_cycle(0, 1'b1, 3, model_data, 32'h100, 1'b0, '0, 1'b0);
      wait_drain();
      repeat (3) @(negedge fclk);
      chk("hold_data", rsp_data, model_data);

      // minimum-latency read from requester 1
      model_data = {4{32'h5A5A_0001}};
      push_exp(1, 1'b0, 3);
      request(1, 32'h140, 1'b0, '0, 2'b00);
      mem_cycle(0, 1'b1, 0, model_data, 32'h140, 1'b0, '0, 1'b0);
      wait_drain();

      // contention: both requesters held
      base = grant_log.size();
      req_addr[0] = 32'h200;
      req_addr[1] = 32'h300;
      req_we      = 2'b00;
      @(posedge fclk); #1;
      req_valid = 2'b11;
      for (int t = 0; t < 4; t++) begin
         model_data = {4{32'hC0DE_0000 + t}};
         push_exp(t % 2, 1'b0, -1);
         mem_cycle(0, 1'b1, 1, model_data, (t % 2 == 0) ? 32'h200 : 32'h300, 1'b0, '0, 1'b0);
      end
      req_valid = 2'b00;
      wait_drain();
      chk("contention_count", grant_log.size() - base, 4);
      for (int t = 0; t < 4; t++) begin
         if (grant_log.size() > base + t) chk("contention_order", grant_log[base + t], t % 2);
      end

      // write: completes like a read, rsp_data untouched
      push_exp(0, 1'b0, -1);
      request(0, 32'h400, 1'b1, {4{32'h1357_9BDF}}, 2'b00);
      mem_cycle(0, 1'b1, 2, {4{32'hFFFF_EEEE}}, 32'h400, 1'b1, {4{32'h1357_9BDF}}, 1'b0);
      wait_drain();

      // backpressure with the other requester pending and stray completions during ISSUE
      base = grant_log.size();
      model_data = {4{32'hB0B0_0005}};
      push_exp(0, 1'b0, -1);
      request(0, 32'h500, 1'b0, '0, 2'b00);
      req_addr[1]  = 32'h510;
      req_valid[1] = 1'b1;
      mem_cycle(5, 1'b1, 0, model_data, 32'h500, 1'b0, '0, 1'b1);
      req_valid[1] = 1'b0;
      wait_drain();
      chk("stall_grants", grant_log.size() - base, 1);

      // timeout: no completion at all
      push_exp(1, 1'b1, 10);
      request(1, 32'h600, 1'b0, '0, 2'b00);
      mem_cycle(0, 1'b0, 0, '0, 32'h600, 1'b0, '0, 1'b0);
      wait_drain();

      // completion in the expiry cycle
      model_data = {4{32'h7E57_0007}};
      push_exp(0, 1'b0, 10);
      request(0, 32'h700, 1'b0, '0, 2'b00);
      mem_cycle(0, 1'b1, 7, model_data, 32'h700, 1'b0, '0, 1'b0);
      wait_drain();

      // reset while WAITing, then a stray completion
      request(1, 32'h800, 1'b0, '0, 2'b00);
      mem_cycle(0, 1'b0, 0, '0, 32'h800, 1'b0, '0, 1'b0);
      @(posedge fclk); #1;
      rst = 1'b1;
      @(posedge fclk); #1;
      rst = 1'b0;
      @(negedge fclk);
      model_data = '0;
      chk("midrst_rsp_data", rsp_data, 128'h0);
      chk("midrst_mem_req_valid", mem_req_valid, 1'b0);
      base_rsp = rsp_count;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {4{32'hBADD_BADD}};
      @(posedge fclk); #1;
      mem_rsp_valid = 1'b0;
      repeat (5) @(negedge fclk);
      chk("stray_ignored", rsp_count - base_rsp, 0);
      chk("stray_data", rsp_data, 128'h0);

      base = grant_log.size();
      model_data = {4{32'h0FF1_0009}};
      push_exp(0, 1'b0, 3);
      req_addr[1] = 32'h900;
      request(0, 32'h880, 1'b0, '0, 2'b10);
      req_valid[1] = 1'b0;
      chk("post_rst_granted", grant_log.size() > base, 1'b1);
      if (grant_log.size() > base) chk("post_rst_grant0", grant_log[base], 0);
      mem_cycle(0, 1'b1, 0, model_data, 32'h880, 1'b0, '0, 1'b0);
      wait_drain();

      repeat (2) @(negedge fclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
